// File: rtl/timer_arbiter_pkg.sv
// rtl/timer_arbiter_pkg.sv - shared state encoding and width helper for timer_arbiter
package timer_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/timer_arbiter_countdown.sv
// rtl/timer_arbiter_countdown.sv - load/done countdown counter shared by all requesters
module countdown #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic             dn
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // No reset port: the arbiter clears count by loading 0 while rst is high.
    always_comb begin
        count_d = count_q;
        if (ld) begin
            count_d = d;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign dn = (count_q == '0);

endmodule

// File: rtl/timer_arbiter.sv
// rtl/timer_arbiter.sv - round-robin scheduler for one countdown timer; TIMER_ARBITER_ABORT_EN enables abort on req drop
module timer_arbiter
    import timer_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_delay,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       dn,
    output logic                  busy
);

    localparam int IW = clog2(NREQ);

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] dn_q, dn_d;
    logic            busy_q, busy_d;
    logic [IW-1:0]   win_q, win_d;
    logic [IW-1:0]   last_grant_q, last_grant_d;

    logic            found;
    logic [IW-1:0]   win_idx;
    logic [IW:0]     scan_idx;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] cnt_d;
    logic            cnt_ld;
    logic            cnt_dn;
    logic [NREQ-1:0] win_oh;
    logic [NREQ-1:0] run_oh;

    // Scan starts one past the last grant, wrapping, so every requester gets a turn.
    always_comb begin
        found    = 1'b0;
        win_idx  = '0;
        scan_idx = '0;
        for (int i = 1; i <= NREQ; i++) begin
            scan_idx = {1'b0, last_grant_q} + (IW+1)'(i);
            if (scan_idx >= (IW+1)'(NREQ)) begin
                scan_idx = scan_idx - (IW+1)'(NREQ);
            end
            if (!found && req[scan_idx[IW-1:0]]) begin
                found   = 1'b1;
                win_idx = scan_idx[IW-1:0];
            end
        end
    end

    always_comb begin
        load_val = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == IW'(i)) begin
                load_val = req_delay[i*WIDTH +: WIDTH];
            end
        end
    end

    assign win_oh = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
    assign run_oh = {{(NREQ-1){1'b0}}, 1'b1} << win_q;

    assign cnt_ld = rst || ((state_q == IDLE) && found);
    assign cnt_d  = rst ? '0 : load_val;

    countdown #(
        .WIDTH (WIDTH)
    ) u_countdown (
        .clk (clk),
        .ld  (cnt_ld),
        .d   (cnt_d),
        .dn  (cnt_dn)
    );

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        dn_d         = '0;
        busy_d       = busy_q;
        win_d        = win_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = RUN;
                    gnt_d   = win_oh;
                    busy_d  = 1'b1;
                    win_d   = win_idx;
                end
            end
            RUN: begin
                if (cnt_dn) begin
                    state_d      = IDLE;
                    gnt_d        = '0;
                    busy_d       = 1'b0;
                    dn_d         = run_oh;
                    last_grant_d = win_q;
                end
`ifdef TIMER_ARBITER_ABORT_EN
                // A dropped request wins over a same-cycle expiry: no done pulse.
                if (!req[win_q]) begin
                    state_d      = IDLE;
                    gnt_d        = '0;
                    busy_d       = 1'b0;
                    dn_d         = '0;
                    last_grant_d = win_q;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            dn_q         <= '0;
            busy_q       <= 1'b0;
            win_q        <= '0;
            last_grant_q <= IW'(NREQ - 1);
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            dn_q         <= dn_d;
            busy_q       <= busy_d;
            win_q        <= win_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign gnt  = gnt_q;
    assign dn   = dn_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// tb/tb_timer_arbiter.sv - directed self-checking bench for timer_arbiter
module tb_timer_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_delay;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       dn;
    logic                  busy;

    int checks;
    int failures;

    timer_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_delay (req_delay),
        .gnt       (gnt),
        .dn        (dn),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // One isolated request: grant, D quiet edges, done pulse, then release.
    task automatic serve(input int who, input int dly);
        logic [NREQ-1:0] oh;
        oh      = '0;
        oh[who] = 1'b1;
        req     = oh;
        req_delay[who*WIDTH +: WIDTH] = WIDTH'(dly);
        tick();
        check("grant", gnt, oh);
        check("busy_on", busy, 1);
        for (int k = 1; k <= dly; k++) begin
            tick();
            check("dn_early", dn, 0);
            check("gnt_held", gnt, oh);
        end
        tick();
        check("dn_pulse", dn, oh);
        check("gnt_off", gnt, 0);
        check("busy_off", busy, 0);
        req = '0;
        tick();
        check("dn_one_cycle", dn, 0);
    endtask

    initial begin
        logic [NREQ-1:0] exp_seq [5];
        checks    = 0;
        failures  = 0;
        rst       = 1'b0;
        req       = '0;
        req_delay = '0;

        // 1: reset state, then D=91 to requester 0
        do_reset();
        check("rst_gnt", gnt, 0);
        check("rst_dn", dn, 0);
        check("rst_busy", busy, 0);
        serve(0, 91);

        // 2: D=0 boundary
        serve(2, 0);

        // 3: all four requesting, round-robin from requester 0 after reset
        do_reset();
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        req_delay = {4{8'd3}};
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            tick();
            check("rr_grant", gnt, exp_seq[n]);
            for (int k = 1; k <= 3; k++) begin
                tick();
                check("rr_dn_quiet", dn, 0);
            end
            tick();
            check("rr_dn", dn, exp_seq[n]);
            check("rr_busy_off", busy, 0);
        end
        req = '0;
        do_reset();

        // 4: reset mid-run loses the timing
        req = 4'b0010;
        req_delay[1*WIDTH +: WIDTH] = 8'd20;
        tick();
        check("t4_grant", gnt, 4'b0010);
        for (int k = 0; k < 10; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = '0;
        check("t4_rst_gnt", gnt, 0);
        check("t4_rst_busy", busy, 0);
        for (int k = 0; k < 25; k++) begin
            tick();
            check("t4_no_dn", dn, 0);
        end
        serve(1, 2);

        // 5: requester drops req four cycles into the run
        req = 4'b0100;
        req_delay[2*WIDTH +: WIDTH] = 8'd20;
        tick();
        check("t5_grant", gnt, 4'b0100);
        for (int k = 1; k <= 3; k++) tick();
        req = '0;
`ifdef TIMER_ARBITER_ABORT_EN
        tick();
        check("t5_abort_gnt", gnt, 0);
        check("t5_abort_busy", busy, 0);
        check("t5_abort_dn", dn, 0);
        for (int k = 0; k < 20; k++) begin
            tick();
            check("t5_no_dn", dn, 0);
        end
`else
        for (int k = 4; k <= 20; k++) begin
            tick();
            check("t5_dn_quiet", dn, 0);
            check("t5_gnt_held", gnt, 4'b0100);
        end
        tick();
        check("t5_dn", dn, 4'b0100);
        tick();
        check("t5_dn_one", dn, 0);
`endif

        // 6: single requester held high, delay changed mid-run
        req = 4'b0010;
        req_delay[1*WIDTH +: WIDTH] = 8'd5;
        tick();
        check("t6_grant1", gnt, 4'b0010);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("t6_dn_quiet1", dn, 0);
            if (k == 2) req_delay[1*WIDTH +: WIDTH] = 8'd50;
            if (k == 5) req_delay[1*WIDTH +: WIDTH] = 8'd5;
        end
        tick();
        check("t6_dn1", dn, 4'b0010);
        tick();
        check("t6_grant2", gnt, 4'b0010);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("t6_dn_quiet2", dn, 0);
        end
        tick();
        check("t6_dn2", dn, 4'b0010);
        req = '0;
        tick();
        check("t6_idle_gnt", gnt, 0);
        check("t6_idle_dn", dn, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
